min_max_input_ctrl: RTL and testbench
=====================================

// Module: min_max_input_ctrl
// PURPOSE
//   Front-end stage directly upstream of min_max_top. Turns raw board inputs
//   (switches, push-buttons) into the registered com/min/max/osc/value bus that
//   drives min_max_top. It synchronises and debounces the buttons, holds min/max
//   registers guarded by an ordering check, cycles the display mode and
//   generates the osc blink signal.
// PARAMETERS
//   VALSIZE   4           width of sw_i, min_o, max_o, val_o (must match min_max_top)
//   DEBOUNCE  16          cycles a synchronised button level must stay stable to be accepted (>=2)
//   OSC_DIV   25_000_000  clk cycles per osc_o half-period (>=1)
// PORTS
//   clk_i        in   1        system clock, all logic on rising edge
//   rst_ni       in   1        asynchronous reset, active low
//   sw_i         in   VALSIZE  raw switches, asynchronous to clk_i
//   btn_min_i    in   1        raw button: load sw into min
//   btn_max_i    in   1        raw button: load sw into max
//   btn_mode_i   in   1        raw button: advance com_o
//   com_o        out  2        to min_max_top com_i
//   min_o        out  VALSIZE  to min_max_top min_i
//   max_o        out  VALSIZE  to min_max_top max_i
//   osc_o        out  1        to min_max_top osc_i, 50% square wave
//   val_o        out  VALSIZE  to min_max_top val_i
//   err_o        out  1        sticky: last min/max load rejected
// BEHAVIOUR
//   Reset (async, rst_ni=0): com_o=00, min_o=0, max_o=all ones, val_o=0, osc_o=0,
//     err_o=0; sync FFs, debounce counters/levels, osc counter cleared. Release
//     mid-press: button must be seen released-then-pressed before a new press counts.
//   Input sync: every sw_i bit and button through 2 FFs. val_o = synchronised sw
//     registered once more: sw_i change visible on val_o after 3 rising edges.
//   Debounce (per button): counter restarts on every change of the synced level;
//     once level held DEBOUNCE consecutive cycles, debounced level takes it.
//     Press pulse = 1-cycle pulse on debounced 0->1 edge. Release never pulses.
//   Load FSM, states IDLE / CHECK / COMMIT:
//     IDLE: press_min xor press_max -> latch cand=synced sw, target -> CHECK.
//       press_min and press_max same cycle -> no load, err_o=1, stay IDLE.
//     CHECK: min target valid iff cand <= max_o; max target valid iff cand >= min_o
//       (unsigned compare). Valid -> COMMIT; invalid -> err_o=1, IDLE.
//     COMMIT: write cand to min_o or max_o, err_o=0, -> IDLE.
//     Presses arriving in CHECK/COMMIT are dropped (not queued).
//     Equality accepted (min_o==max_o legal). Invariant min_o<=max_o always holds.
//   Mode: each press_mode increments com_o mod 4 (11 -> 00), same cycle as pulse+1;
//     independent of load FSM, may coincide with a load.
//   Osc: counter 0..OSC_DIV-1; at OSC_DIV-1 counter wraps to 0 and osc_o toggles.
//     First toggle OSC_DIV cycles after reset release; period 2*OSC_DIV.
//   All outputs registered; no combinational path input->output.
// TESTING (VALSIZE=4, DEBOUNCE=4, OSC_DIV=3)
//   Reset then run 12 cycles -> com=00,min=0,max=F,err=0; osc toggles every 3 cycles.
//   sw=5, btn_min pulse 2 cycles -> ignored (bounce); held 10 cycles -> min_o=5, err=0.
//   min=5, sw=3, press btn_max -> max_o stays F, err_o=1; then sw=9 btn_max -> max=9, err=0.
//   min=max=7 via sw=7 press min then max -> both 7, err=0 (equality legal).
//   btn_min and btn_max pressed simultaneously, sw=2 -> min/max unchanged, err=1.
//   btn_mode pressed 5 times -> com 01,10,11,00,01; assert rst_ni mid-press -> com=00 at once.

Source files
------------

// File: rtl/min_max_input_ctrl.sv
// min_max_input_ctrl: board-input front end for min_max_top.
// Synchronises switches and buttons, debounces the buttons, loads min/max
// registers behind an ordering check, cycles the display mode and divides the
// clock down to the osc blink signal. Every output is registered.
module min_max_input_ctrl #(
  parameter int VALSIZE  = 4,
  parameter int DEBOUNCE = 16,
  parameter int OSC_DIV  = 25_000_000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [VALSIZE-1:0] sw_i,
  input  logic               btn_min_i,
  input  logic               btn_max_i,
  input  logic               btn_mode_i,
  output logic [1:0]         com_o,
  output logic [VALSIZE-1:0] min_o,
  output logic [VALSIZE-1:0] max_o,
  output logic               osc_o,
  output logic [VALSIZE-1:0] val_o,
  output logic               err_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int OW = $clog2(OSC_DIV + 1);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

  // button index: 0 = min, 1 = max, 2 = mode
  logic [VALSIZE-1:0] sw_s1, sw_s2;
  logic [2:0]         btn_s1, btn_s2;
  logic [2:0]         db_lvl, armed, press;
  logic [CW-1:0]      db_cnt [3];
  logic [OW-1:0]      osc_cnt;
  state_t             state;
  logic [VALSIZE-1:0] cand;
  logic               tgt_max;

  // two-flop synchronisers for switches and buttons, plus the val_o register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      val_o  <= '0;
    end else begin
      sw_s1  <= sw_i;
      sw_s2  <= sw_s1;
      btn_s1 <= {btn_mode_i, btn_max_i, btn_min_i};
      btn_s2 <= btn_s1;
      val_o  <= sw_s2;
    end
  end

  // per-button debounce with one-cycle press pulse on accepted 0->1.
  // Until a button has been seen released for DEBOUNCE cycles it is unarmed:
  // the filter then tracks "released" instead of the level, so a button held
  // across reset release never produces a press. While unarmed both sync
  // stages must read 0, which keeps the cleared synchroniser from faking a
  // release in the first cycles after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_lvl <= '0;
      armed  <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if ((armed[i] ? btn_s2[i] : (btn_s2[i] | btn_s1[i])) ==
            (armed[i] ? db_lvl[i] : 1'b1)) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE - 1)) begin
          db_cnt[i] <= '0;
          if (!armed[i]) begin
            armed[i] <= 1'b1;
          end else begin
            db_lvl[i] <= btn_s2[i];
            press[i]  <= btn_s2[i];
          end
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // load FSM: latch candidate, check ordering against the other bound, commit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cand    <= '0;
      tgt_max <= 1'b0;
      min_o   <= '0;
      max_o   <= '1;
      err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press[0] && press[1]) begin
            err_o <= 1'b1;
          end else if (press[0] || press[1]) begin
            cand    <= sw_s2;
            tgt_max <= press[1];
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (tgt_max ? (cand >= min_o) : (cand <= max_o)) begin
            state <= COMMIT;
          end else begin
            err_o <= 1'b1;
            state <= IDLE;
          end
        end
        COMMIT: begin
          if (tgt_max) max_o <= cand;
          else         min_o <= cand;
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // display mode counter, wraps 3 -> 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) com_o <= '0;
    else if (press[2]) com_o <= com_o + 2'd1;
  end

  // osc divider: toggle every OSC_DIV cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      osc_cnt <= '0;
      osc_o   <= 1'b0;
    end else if (osc_cnt == OW'(OSC_DIV - 1)) begin
      osc_cnt <= '0;
      osc_o   <= ~osc_o;
    end else begin
      osc_cnt <= osc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_min_max_input_ctrl.sv
// Directed testbench for min_max_input_ctrl (VALSIZE=4, DEBOUNCE=4, OSC_DIV=3).
module tb_min_max_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic       btn_min = 1'b0, btn_max = 1'b0, btn_mode = 1'b0;
  logic [1:0] com;
  logic [3:0] min_v, max_v, val;
  logic       osc, err;
  int         checks = 0;
  int         errors = 0;

  min_max_input_ctrl #(.VALSIZE(4), .DEBOUNCE(4), .OSC_DIV(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_i(sw),
    .btn_min_i(btn_min), .btn_max_i(btn_max), .btn_mode_i(btn_mode),
    .com_o(com), .min_o(min_v), .max_o(max_v), .osc_o(osc),
    .val_o(val), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // hold the given buttons 10 cycles, then release and let everything settle
  task automatic press(input logic m, input logic x, input logic d);
    btn_min = m; btn_max = x; btn_mode = d;
    step(10);
    btn_min = 1'b0; btn_max = 1'b0; btn_mode = 1'b0;
    step(12);
  endtask

  task automatic test_reset;
    logic exp_osc;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      exp_osc = ((i / 3) % 2) == 1;
      checks++;
      if (osc !== exp_osc) begin
        errors++;
        $display("FAIL osc cycle %0d: got %b expected %b", i, osc, exp_osc);
      end
    end
    checks++;
    if ({com, min_v, max_v, err} !== {2'b00, 4'h0, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: com=%b min=%h max=%h err=%b expected 00 0 f 0",
               com, min_v, max_v, err);
    end
  endtask

  task automatic test_val;
    sw = 4'hA;
    step(2);
    checks++;
    if (val !== 4'h0) begin
      errors++;
      $display("FAIL val_early: got %h expected 0", val);
    end
    step(1);
    checks++;
    if (val !== 4'hA) begin
      errors++;
      $display("FAIL val_3edges: got %h expected a", val);
    end
  endtask

  task automatic test_debounce;
    sw = 4'h5;
    btn_min = 1'b1;
    step(2);
    btn_min = 1'b0;
    step(15);
    checks++;
    if (min_v !== 4'h0) begin
      errors++;
      $display("FAIL bounce_ignored: min=%h expected 0", min_v);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({min_v, err} !== {4'h5, 1'b0}) begin
      errors++;
      $display("FAIL min_load: min=%h err=%b expected 5 0", min_v, err);
    end
  endtask

  task automatic test_order;
    sw = 4'h3;
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if ({max_v, err} !== {4'hF, 1'b1}) begin
      errors++;
      $display("FAIL max_reject: max=%h err=%b expected f 1", max_v, err);
    end
    sw = 4'h9;
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if ({max_v, err} !== {4'h9, 1'b0}) begin
      errors++;
      $display("FAIL max_load: max=%h err=%b expected 9 0", max_v, err);
    end
    sw = 4'h7;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if ({min_v, max_v, err} !== {4'h7, 4'h7, 1'b0}) begin
      errors++;
      $display("FAIL equal: min=%h max=%h err=%b expected 7 7 0", min_v, max_v, err);
    end
    sw = 4'h2;
    press(1'b1, 1'b1, 1'b0);
    checks++;
    if ({min_v, max_v, err} !== {4'h7, 4'h7, 1'b1}) begin
      errors++;
      $display("FAIL simultaneous: min=%h max=%h err=%b expected 7 7 1", min_v, max_v, err);
    end
    sw = 4'h8;
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({min_v, err} !== {4'h7, 1'b1}) begin
      errors++;
      $display("FAIL min_above_max: min=%h err=%b expected 7 1", min_v, err);
    end
  endtask

  task automatic test_mode;
    logic [1:0] exp_com [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b0, 1'b1);
      checks++;
      if (com !== exp_com[i]) begin
        errors++;
        $display("FAIL mode_%0d: com=%b expected %b", i, com, exp_com[i]);
      end
    end
    btn_mode = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({com, min_v, max_v} !== {2'b00, 4'h0, 4'hF}) begin
      errors++;
      $display("FAIL async_reset: com=%b min=%h max=%h expected 00 0 f", com, min_v, max_v);
    end
    step(2);
    rst_n = 1'b1;
    step(15);
    checks++;
    if (com !== 2'b00) begin
      errors++;
      $display("FAIL held_through_reset: com=%b expected 00", com);
    end
    btn_mode = 1'b0;
    step(12);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (com !== 2'b01) begin
      errors++;
      $display("FAIL press_after_release: com=%b expected 01", com);
    end
  endtask

  initial begin
    test_reset();
    test_val();
    test_debounce();
    test_order();
    test_mode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
